// File: rtl/way_select_pkg.sv
// way_select_pkg: entry type and sizing helpers shared by
// the pipelined way selector and its merge node.
package way_select_pkg;

  localparam int VALUE_W_MAX = 32;
  localparam int PTR_W_MAX   = 6;

  typedef struct packed {
    logic                   valid;
    logic [VALUE_W_MAX-1:0] value;
    logic [PTR_W_MAX-1:0]   ptr;
  } entry_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int stages(input int n, input int lps);
    return (clog2(n) + lps - 1) / lps;
  endfunction

endpackage

// File: rtl/way_select_node.sv
// way_select_node: merges two tree entries; on equal values
// the a-side (lower way index) is kept.
module way_select_node
  import way_select_pkg::*;
(
  input  entry_t i_a,
  input  entry_t i_b,
  input  logic   i_min,
  output entry_t o_y
);

  logic w_b_wins;

  assign w_b_wins = i_min ? (i_b.value < i_a.value)
                          : (i_b.value > i_a.value);

  always_comb begin
    o_y = '0;
    unique case (1'b1)
      i_a.valid && i_b.valid:  o_y = w_b_wins ? i_b : i_a;
      i_a.valid && !i_b.valid: o_y = i_a;
      !i_a.valid && i_b.valid: o_y = i_b;
      default:                 o_y = '0;
    endcase
  end

endmodule

// File: rtl/way_select_pipe.sv
// way_select_pipe: pipelined max/min selector over eligible
// ways with valid/ready handshakes on request and response.
module way_select_pipe
  import way_select_pkg::*;
#(
  parameter  int NUM_WAY          = 16,
  parameter  int VALUE_WIDTH      = 4,
  parameter  int LEVELS_PER_STAGE = 1,
  localparam int PTR_WIDTH        = clog2(NUM_WAY)
) (
  input  logic                           clk_in,
  input  logic                           reset_n_in,
  input  logic                           flush_in,
  input  logic                           req_valid_in,
  output logic                           req_ready_out,
  input  logic                           select_min_in,
  input  logic [VALUE_WIDTH*NUM_WAY-1:0] way_flatted_in,
  input  logic [NUM_WAY-1:0]             condition_in,
  output logic                           resp_valid_out,
  input  logic                           resp_ready_in,
  output logic [VALUE_WIDTH-1:0]         value_out,
  output logic [PTR_WIDTH-1:0]           ptr_out,
  output logic                           found_out
);

  localparam int L = clog2(NUM_WAY);
  localparam int P = stages(NUM_WAY, LEVELS_PER_STAGE);

  // heap order: node n merges 2n and 2n+1, leaves at NUM_WAY+i
  entry_t w_src [1:2*NUM_WAY-1];

  logic [P-1:0] r_vld;
  logic [P-1:0] r_min;
  logic [P-1:0] w_load;
  logic [P-1:0] w_in_vld;
  logic [P-1:0] w_smin;
  logic [P-1:0] w_ld;
  logic         w_unused;

  assign req_ready_out = w_load[0] && !flush_in;

  for (genvar s = 0; s < P; s++) begin : g_stage
    // a stage can load if any stage at or after it has a hole
    assign w_load[s] = resp_ready_in || (|(~r_vld >> s));

    if (s == 0) begin : g_head
      assign w_in_vld[s] = req_valid_in;
      assign w_smin[s]   = select_min_in;
    end else begin : g_body
      assign w_in_vld[s] = r_vld[s-1];
      assign w_smin[s]   = r_min[s-1];
    end

    assign w_ld[s] = w_load[s] && w_in_vld[s] && !flush_in;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
        r_vld[s] <= 1'b0;
        r_min[s] <= 1'b0;
      end else if (flush_in) begin
        r_vld[s] <= 1'b0;
      end else if (w_load[s]) begin
        r_vld[s] <= w_in_vld[s];
        if (w_in_vld[s]) r_min[s] <= w_smin[s];
      end
    end
  end

  for (genvar i = 0; i < NUM_WAY; i++) begin : g_leaf
    assign w_src[NUM_WAY+i] = '{
      valid: condition_in[i],
      value: VALUE_W_MAX'(way_flatted_in[i*VALUE_WIDTH +: VALUE_WIDTH]),
      ptr:   PTR_W_MAX'(i)
    };
  end

  for (genvar n = 1; n < NUM_WAY; n++) begin : g_node
    localparam int LEV = L - (clog2(n + 1) - 1);
    localparam int STG = (LEV - 1) / LEVELS_PER_STAGE;

    entry_t w_y;

    way_select_node u_node (
      .i_a   (w_src[2*n]),
      .i_b   (w_src[2*n+1]),
      .i_min (w_smin[STG]),
      .o_y   (w_y)
    );

    if ((LEV % LEVELS_PER_STAGE == 0) || (LEV == L)) begin : g_reg
      entry_t r_q;

      always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) r_q <= '0;
        else if (w_ld[STG]) r_q <= w_y;
      end

      assign w_src[n] = r_q;
    end else begin : g_comb
      assign w_src[n] = w_y;
    end
  end

  assign resp_valid_out = r_vld[P-1];
  assign value_out      = w_src[1].value[VALUE_WIDTH-1:0];
  assign ptr_out        = w_src[1].ptr[PTR_WIDTH-1:0];
  assign found_out      = w_src[1].valid;

  assign w_unused = ^{w_src[1].value >> VALUE_WIDTH,
                      w_src[1].ptr >> PTR_WIDTH,
                      r_min[P-1]};

endmodule

// File: tb/tb_way_select_pipe.sv
// tb_way_select_pipe: directed checks of the 8-way, 3-stage
// configuration against hand-computed results.
module tb_way_select_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic        smin;
  logic [31:0] way_flat;
  logic [7:0]  cond;
  logic        resp_valid;
  logic        resp_ready;
  logic [3:0]  value;
  logic [2:0]  ptr;
  logic        found;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] t_c [6];
  logic       t_m [6];
  logic [3:0] t_v [6];
  logic [2:0] t_p [6];
  logic       t_f [6];

  always #5 clk = ~clk;

  way_select_pipe #(
    .NUM_WAY          (8),
    .VALUE_WIDTH      (4),
    .LEVELS_PER_STAGE (1)
  ) dut (
    .clk_in         (clk),
    .reset_n_in     (rst_n),
    .flush_in       (flush),
    .req_valid_in   (req_valid),
    .req_ready_out  (req_ready),
    .select_min_in  (smin),
    .way_flatted_in (way_flat),
    .condition_in   (cond),
    .resp_valid_out (resp_valid),
    .resp_ready_in  (resp_ready),
    .value_out      (value),
    .ptr_out        (ptr),
    .found_out      (found)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int k, input string tag);
    int n;
    cond = t_c[k];
    smin = t_m[k];
    req_valid = 1'b1;
    resp_ready = 1'b1;
    #1;
    check({tag, "_rdy"}, 32'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 2);
    check({tag, "_val"}, 32'(value), 32'(t_v[k]));
    check({tag, "_ptr"}, 32'(ptr), 32'(t_p[k]));
    check({tag, "_fnd"}, 32'(found), 32'(t_f[k]));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k_req;
    int deliv;
    int last_cyc;
    int seen;

    // ways 0..7 = 3,9,2,9,0,1,7,5
    way_flat = 32'h5710_9293;
    t_c[0] = 8'hFF; t_m[0] = 0; t_v[0] = 9; t_p[0] = 1; t_f[0] = 1;
    t_c[1] = 8'hEF; t_m[1] = 1; t_v[1] = 1; t_p[1] = 5; t_f[1] = 1;
    t_c[2] = 8'h10; t_m[2] = 1; t_v[2] = 0; t_p[2] = 4; t_f[2] = 1;
    t_c[3] = 8'hF5; t_m[3] = 0; t_v[3] = 7; t_p[3] = 6; t_f[3] = 1;
    t_c[4] = 8'h00; t_m[4] = 0; t_v[4] = 0; t_p[4] = 0; t_f[4] = 0;
    t_c[5] = 8'hFF; t_m[5] = 1; t_v[5] = 0; t_p[5] = 4; t_f[5] = 1;

    rst_n = 1'b0;
    flush = 1'b0;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    smin = 1'b0;
    cond = 8'h00;

    tick();
    tick();
    check("rst_vld", 32'(resp_valid), 0);
    check("rst_val", 32'(value), 0);
    check("rst_ptr", 32'(ptr), 0);
    check("rst_fnd", 32'(found), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_rdy", 32'(req_ready), 1);

    run(0, "max_all");
    run(1, "min_mask");
    run(2, "min_one");
    run(3, "max_excl");
    run(4, "none");

    // backpressure: response side stalled for cycles 0..4
    k_req = 0;
    deliv = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 30 && deliv < 6; cyc++) begin
      resp_ready = (cyc >= 5);
      req_valid = (k_req < 6);
      if (k_req < 6) begin
        cond = t_c[k_req];
        smin = t_m[k_req];
      end
      #1;
      if (cyc == 3) begin
        check("bp_acc", 32'(k_req), 3);
        check("bp_rdy", 32'(req_ready), 0);
        check("bp_vld", 32'(resp_valid), 1);
      end
      if (cyc == 4) check("bp_hold", 32'(value), 32'(t_v[0]));
      if (resp_valid && resp_ready) begin
        check("bp_val", 32'(value), 32'(t_v[deliv]));
        check("bp_ptr", 32'(ptr), 32'(t_p[deliv]));
        check("bp_fnd", 32'(found), 32'(t_f[deliv]));
        if (deliv > 0) check("bp_gap", 32'(cyc - last_cyc), 1);
        last_cyc = cyc;
        deliv++;
      end
      if (req_valid && req_ready) k_req++;
      tick();
    end
    req_valid = 1'b0;
    check("bp_cnt", 32'(deliv), 6);
    tick();
    tick();

    // flush with two requests in flight
    resp_ready = 1'b1;
    req_valid = 1'b1;
    cond = t_c[0];
    smin = t_m[0];
    tick();
    cond = t_c[1];
    smin = t_m[1];
    tick();
    flush = 1'b1;
    #1;
    check("fl_rdy", 32'(req_ready), 0);
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) seen++;
      tick();
    end
    check("fl_none", 32'(seen), 0);

    // reset while a response is parked at the output
    resp_ready = 1'b0;
    req_valid = 1'b1;
    cond = t_c[3];
    smin = t_m[3];
    tick();
    req_valid = 1'b0;
    cond = t_c[0];
    tick();
    tick();
    check("rs_pre_vld", 32'(resp_valid), 1);
    check("rs_pre_val", 32'(value), 7);
    rst_n = 1'b0;
    #1;
    check("rs_vld", 32'(resp_valid), 0);
    check("rs_val", 32'(value), 0);
    check("rs_ptr", 32'(ptr), 0);
    check("rs_fnd", 32'(found), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run(3, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
